// File: rtl/hidden_layer_mac.sv
// Single-neuron evaluator: y = act(bias + sum w[k]*x[k]) using one shared MAC
// stepped over NUM_IN lanes, with a writable weight/bias bank and valid/ready ports.
module hidden_layer_mac #(
    parameter int NUM_IN = 4,
    parameter int XW     = 4,
    parameter int WW     = 8,
    parameter int YW     = 10,
    parameter int AW     = $clog2(NUM_IN + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [NUM_IN*XW-1:0] x_i,
    input  logic                 w_we_i,
    input  logic [AW-1:0]        w_addr_i,
    input  logic [WW-1:0]        w_data_i,
    input  logic                 mode_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [YW-1:0]        y_o,
    output logic                 sat_o,
    output logic                 busy_o
);

    localparam int ACCW = XW + WW + $clog2(NUM_IN + 1) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_IN - 1);
    localparam logic [AW-1:0] BIAS_ADDR = AW'(NUM_IN);
    localparam logic [AW-1:0] IDX_ONE   = {{(AW-1){1'b0}}, 1'b1};

    localparam logic signed [ACCW-1:0] Y_MAX = {{(ACCW-YW+1){1'b0}}, {(YW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] Y_MIN = {{(ACCW-YW+1){1'b1}}, {(YW-1){1'b0}}};

    logic [1:0]                 state_r;
    logic signed [WW-1:0]       w_r [NUM_IN];
    logic signed [WW-1:0]       bias_r;
    logic [NUM_IN*XW-1:0]       x_lat_r;
    logic                       mode_r;
    logic [AW-1:0]              idx_r;
    logic signed [ACCW-1:0]     acc_r;
    logic [YW-1:0]              y_r;
    logic                       sat_r;
    logic                       in_ready_r;
    logic                       out_valid_r;
    logic                       busy_r;

    logic signed [XW-1:0]       x_sel_s;
    logic signed [WW-1:0]       w_sel_s;
    logic signed [ACCW-1:0]     x_ext_s;
    logic signed [ACCW-1:0]     w_ext_s;
    logic signed [ACCW-1:0]     bias_ext_s;
    logic signed [ACCW-1:0]     acc_next_s;
    logic [YW-1:0]              y_res_s;
    logic                       sat_res_s;

    // Lane and weight selected by the MAC step counter
    always_comb begin
        x_sel_s = {XW{1'b0}};
        w_sel_s = {WW{1'b0}};
        for (int k = 0; k < NUM_IN; k++) begin
            x_sel_s = (idx_r == AW'(k)) ? x_lat_r[k*XW +: XW] : x_sel_s;
            w_sel_s = (idx_r == AW'(k)) ? w_r[k] : w_sel_s;
        end
    end

    // One multiply-accumulate step, operands widened so the product cannot wrap
    always_comb begin
        x_ext_s    = {{(ACCW-XW){x_sel_s[XW-1]}}, x_sel_s};
        w_ext_s    = {{(ACCW-WW){w_sel_s[WW-1]}}, w_sel_s};
        bias_ext_s = {{(ACCW-WW){bias_r[WW-1]}}, bias_r};
        acc_next_s = acc_r + (x_ext_s * w_ext_s);
    end

    // Activation and clipping of the final sum to the output range
    always_comb begin
        y_res_s   = acc_next_s[YW-1:0];
        sat_res_s = 1'b0;
        if (mode_r && acc_next_s[ACCW-1]) begin
            y_res_s   = {YW{1'b0}};
            sat_res_s = 1'b0;
        end else if (acc_next_s > Y_MAX) begin
            y_res_s   = Y_MAX[YW-1:0];
            sat_res_s = 1'b1;
        end else if (acc_next_s < Y_MIN) begin
            y_res_s   = Y_MIN[YW-1:0];
            sat_res_s = 1'b1;
        end else begin
            y_res_s   = acc_next_s[YW-1:0];
            sat_res_s = 1'b0;
        end
    end

    // Weight/bias bank; only writable while idle so an evaluation sees one set
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NUM_IN; k++) begin
                w_r[k] <= {WW{1'b0}};
            end
            bias_r <= {WW{1'b0}};
        end else if (en_i && w_we_i && (state_r == IDLE)) begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (w_addr_i == AW'(k)) begin
                    w_r[k] <= w_data_i;
                end
            end
            if (w_addr_i == BIAS_ADDR) begin
                bias_r <= w_data_i;
            end
        end
    end

    // Control FSM, accumulator and registered handshake/result outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= IDLE;
            x_lat_r     <= {(NUM_IN*XW){1'b0}};
            mode_r      <= 1'b0;
            idx_r       <= {AW{1'b0}};
            acc_r       <= {ACCW{1'b0}};
            y_r         <= {YW{1'b0}};
            sat_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (en_i) begin
            case (state_r)
                IDLE: begin
                    if (in_valid_i) begin
                        x_lat_r    <= x_i;
                        mode_r     <= mode_i;
                        acc_r      <= bias_ext_s;
                        idx_r      <= {AW{1'b0}};
                        state_r    <= ACC;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ACC: begin
                    acc_r <= acc_next_s;
                    idx_r <= idx_r + IDX_ONE;
                    if (idx_r == IDX_LAST) begin
                        y_r         <= y_res_s;
                        sat_r       <= sat_res_s;
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // ready is deliberately not raised here: no same-cycle re-accept
                    if (out_ready_i) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign y_o         = y_r;
    assign sat_o       = sat_r;
    assign busy_o      = busy_r;

endmodule
